// File: rtl/ofm_pkg.sv
// ofm_pkg: shared types and field layout for the OFM transmit scheduler.
//   - ofm_state_e     : scheduler FSM states
//   - DESC_*          : descriptor word layout (length, drop flag)
//   - BEAT_*          : data beat layout {tlast, tkeep, tdata}
//   - OFM_MAX_LEN_DEF : default maximum legal frame length in bytes
//   - last_tkeep()    : byte-enable mask for the final beat of a frame
//   - beats_of()      : number of 8-byte beats covering a byte length
package ofm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2,
    ST_DROP = 2'd3
  } ofm_state_e;

  localparam int unsigned OFM_MAX_LEN_DEF = 9600;

  localparam int unsigned DESC_W        = 34;
  localparam int unsigned DESC_LEN_LSB  = 0;
  localparam int unsigned DESC_LEN_W    = 16;
  localparam int unsigned DESC_DROP_BIT = 33;

  localparam int unsigned BEAT_W         = 73;
  localparam int unsigned BEAT_TDATA_LSB = 0;
  localparam int unsigned BEAT_TDATA_W   = 64;
  localparam int unsigned BEAT_TKEEP_LSB = 64;
  localparam int unsigned BEAT_TKEEP_W   = 8;
  localparam int unsigned BEAT_TLAST_BIT = 72;

  localparam int unsigned BCNT_W = 13;

  // A zero remainder means the last beat is completely full.
  function automatic logic [7:0] last_tkeep(input logic [2:0] rem);
    if (rem == 3'd0) begin
      last_tkeep = 8'hFF;
    end else begin
      last_tkeep = 8'((9'd1 << rem) - 9'd1);
    end
  endfunction

  function automatic logic [BCNT_W-1:0] beats_of(input logic [15:0] len);
    beats_of = BCNT_W'(({1'b0, len} + 17'd7) >> 3);
  endfunction

endpackage

// File: rtl/ofm_stat_cnt.sv
// ofm_stat_cnt: 32-bit saturating event counter.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : count one event this cycle
//   cnt_o  : current count, holds at all-ones
module ofm_stat_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ofm_tx_sched.sv
// ofm_tx_sched: moves frames from a beat FIFO to the MAC TX FIFO under
// control of a per-frame descriptor FIFO, trimming/terminating each frame
// at the descriptor length and discarding dropped or malformed frames.
//   tx_clk, sys_rst_n            : clock, async active-low reset
//   sched_en                     : allow new descriptors to be taken
//   ctrl_fifo_rdata/empty/rden   : descriptor FIFO (FWFT) {drop, -, len}
//   data_fifo_rdata/empty/rden   : beat FIFO (FWFT) {tlast, tkeep, tdata}
//   tx_fifo_wdata/wren/afull     : MAC-side TX FIFO, same beat format
//   busy                         : scheduler not idle
//   stat_tx_frames/drop/len_err  : saturating statistics
module ofm_tx_sched
  import ofm_pkg::*;
#(
  parameter int unsigned C_MAX_LEN = OFM_MAX_LEN_DEF
) (
  input  logic              tx_clk,
  input  logic              sys_rst_n,
  input  logic              sched_en,
  input  logic [DESC_W-1:0] ctrl_fifo_rdata,
  input  logic              ctrl_fifo_empty,
  output logic              ctrl_fifo_rden,
  input  logic [BEAT_W-1:0] data_fifo_rdata,
  input  logic              data_fifo_empty,
  output logic              data_fifo_rden,
  output logic [BEAT_W-1:0] tx_fifo_wdata,
  output logic              tx_fifo_wren,
  input  logic              tx_fifo_afull,
  output logic              busy,
  output logic [31:0]       stat_tx_frames,
  output logic [31:0]       stat_drop_frames,
  output logic [31:0]       stat_len_err
);

  localparam logic [16:0] MAX_LEN = 17'(C_MAX_LEN);

  ofm_state_e        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic              drop_q, drop_d;
  logic [BCNT_W-1:0] rem_q, rem_d;
  logic              from_load_q, from_load_d;

  logic              in_tlast;
  logic              last_cnt;
  logic              fire;
  logic              len_bad;
  logic              inc_tx, inc_drop, inc_lerr;
  logic [BEAT_W-1:0] beat_out;
  logic              unused_desc_bits;

  assign unused_desc_bits = ^ctrl_fifo_rdata[32:16];

  assign in_tlast = data_fifo_rdata[BEAT_TLAST_BIT];
  assign last_cnt = (rem_q == BCNT_W'(1));
  assign fire     = !data_fifo_empty && !tx_fifo_afull;
  assign len_bad  = drop_q || (len_q == '0) || ({1'b0, len_q} > MAX_LEN);

  always_ff @(posedge tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      drop_q      <= 1'b0;
      rem_q       <= '0;
      from_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      drop_q      <= drop_d;
      rem_q       <= rem_d;
      from_load_q <= from_load_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    drop_d         = drop_q;
    rem_d          = rem_q;
    from_load_d    = from_load_q;
    ctrl_fifo_rden = 1'b0;
    data_fifo_rden = 1'b0;
    tx_fifo_wren   = 1'b0;
    inc_tx         = 1'b0;
    inc_drop       = 1'b0;
    inc_lerr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The FWFT head is captured on the popping edge; in LOAD the FIFO
        // output already shows the following descriptor. The pop strobe
        // is gated by reset because IDLE is also the reset state.
        if (sched_en && !ctrl_fifo_empty) begin
          ctrl_fifo_rden = sys_rst_n;
          len_d          = ctrl_fifo_rdata[DESC_LEN_LSB +: DESC_LEN_W];
          drop_d         = ctrl_fifo_rdata[DESC_DROP_BIT];
          state_d        = ST_LOAD;
        end
      end

      ST_LOAD: begin
        rem_d       = beats_of(len_q);
        from_load_d = len_bad;
        state_d     = len_bad ? ST_DROP : ST_XFER;
      end

      ST_XFER: begin
        data_fifo_rden = fire;
        tx_fifo_wren   = fire;
        if (fire) begin
          rem_d = rem_q - BCNT_W'(1);
          if (last_cnt) begin
            if (in_tlast) begin
              inc_tx  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              // Source frame runs long: terminate here, discard the rest.
              inc_lerr    = 1'b1;
              from_load_d = 1'b0;
              state_d     = ST_DROP;
            end
          end else if (in_tlast) begin
            inc_tx   = 1'b1;
            inc_lerr = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        data_fifo_rden = !data_fifo_empty;
        if (!data_fifo_empty && in_tlast) begin
          inc_drop = from_load_q;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_out = data_fifo_rdata;
    if (last_cnt) begin
      beat_out[BEAT_TLAST_BIT]                  = 1'b1;
      beat_out[BEAT_TKEEP_LSB +: BEAT_TKEEP_W]  = last_tkeep(len_q[2:0]);
    end
  end

  assign tx_fifo_wdata = tx_fifo_wren ? beat_out : '0;
  assign busy          = (state_q != ST_IDLE);

  ofm_stat_cnt u_stat_tx (
    .clk_i  (tx_clk),
    .rst_ni (sys_rst_n),
    .inc_i  (inc_tx),
    .cnt_o  (stat_tx_frames)
  );

  ofm_stat_cnt u_stat_drop (
    .clk_i  (tx_clk),
    .rst_ni (sys_rst_n),
    .inc_i  (inc_drop),
    .cnt_o  (stat_drop_frames)
  );

  ofm_stat_cnt u_stat_lerr (
    .clk_i  (tx_clk),
    .rst_ni (sys_rst_n),
    .inc_i  (inc_lerr),
    .cnt_o  (stat_len_err)
  );

endmodule

// File: tb/tb_ofm_tx_sched.sv
module tb_ofm_tx_sched;

  localparam int unsigned MAXL = 9600;

  logic        tx_clk = 1'b0;
  logic        sys_rst_n;
  logic        sched_en;
  logic [33:0] ctrl_fifo_rdata;
  logic        ctrl_fifo_empty;
  logic        ctrl_fifo_rden;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [72:0] tx_fifo_wdata;
  logic        tx_fifo_wren;
  logic        tx_fifo_afull;
  logic        busy;
  logic [31:0] stat_tx_frames, stat_drop_frames, stat_len_err;

  always #5 tx_clk = ~tx_clk;

  ofm_tx_sched #(.C_MAX_LEN(MAXL)) dut (
    .tx_clk           (tx_clk),
    .sys_rst_n        (sys_rst_n),
    .sched_en         (sched_en),
    .ctrl_fifo_rdata  (ctrl_fifo_rdata),
    .ctrl_fifo_empty  (ctrl_fifo_empty),
    .ctrl_fifo_rden   (ctrl_fifo_rden),
    .data_fifo_rdata  (data_fifo_rdata),
    .data_fifo_empty  (data_fifo_empty),
    .data_fifo_rden   (data_fifo_rden),
    .tx_fifo_wdata    (tx_fifo_wdata),
    .tx_fifo_wren     (tx_fifo_wren),
    .tx_fifo_afull    (tx_fifo_afull),
    .busy             (busy),
    .stat_tx_frames   (stat_tx_frames),
    .stat_drop_frames (stat_drop_frames),
    .stat_len_err     (stat_len_err)
  );

  // Source FIFO contents and the scoreboard of expected TX beats.
  logic [33:0] cq[$];
  logic [72:0] dq[$];
  logic [72:0] exp_q[$];

  int unsigned tests = 0, fails = 0;
  int unsigned mon_wr = 0, mon_rd = 0, mon_crd = 0;
  int unsigned exp_wr = 0, exp_rd = 0;
  int unsigned m_tx = 0, m_drop = 0, m_lerr = 0;
  int unsigned afull_pct = 0;
  logic        hold_afull = 1'b0;

  task automatic chk_n(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_b(input string nm, input logic [72:0] act, input logic [72:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic refresh();
    ctrl_fifo_empty = (cq.size() == 0);
    ctrl_fifo_rdata = (cq.size() != 0) ? cq[0] : '0;
    data_fifo_empty = (dq.size() == 0);
    data_fifo_rdata = (dq.size() != 0) ? dq[0] : '0;
  endtask

  // FWFT FIFO models: strobes sampled mid-cycle, applied just after the edge.
  initial begin : fifo_model
    logic pop_c, pop_d;
    tx_fifo_afull = 1'b0;
    refresh();
    forever begin
      @(negedge tx_clk);
      pop_c = ctrl_fifo_rden;
      pop_d = data_fifo_rden;
      @(posedge tx_clk);
      #1;
      if (pop_c && cq.size() != 0) void'(cq.pop_front());
      if (pop_d && dq.size() != 0) void'(dq.pop_front());
      tx_fifo_afull = hold_afull || ($urandom_range(99) < afull_pct);
      refresh();
    end
  end

  // Monitor: checks every presented TX beat against the scoreboard.
  initial begin : monitor
    logic [72:0] e;
    forever begin
      @(negedge tx_clk);
      if (ctrl_fifo_rden) begin
        mon_crd++;
        chk_n("ctrl_rden_only_idle", 32'(busy), 32'd0);
      end
      if (data_fifo_rden) mon_rd++;
      if (tx_fifo_afull) chk_n("no_wren_when_afull", 32'(tx_fifo_wren), 32'd0);
      if (tx_fifo_wren) begin
        mon_wr++;
        chk_n("wren_with_rden", 32'(data_fifo_rden), 32'd1);
        if (exp_q.size() == 0) begin
          chk_b("unexpected_beat", tx_fifo_wdata, 73'd0);
          if (tx_fifo_wdata == 73'd0) begin
            fails++;
            $display("FAIL unexpected_beat: got a write, expected none");
          end
        end else begin
          e = exp_q.pop_front();
          chk_b("tx_beat", tx_fifo_wdata, e);
        end
      end else begin
        chk_b("wdata_zero_when_idle", tx_fifo_wdata, 73'd0);
      end
    end
  end

  // Reference: derive the expected TX beats and statistics for one frame
  // from its descriptor and source beats.
  task automatic send_frame(input logic [15:0] len, input logic drop,
                            input int unsigned nb, input logic with_desc);
    logic [72:0] beats[$];
    logic [72:0] b;
    int unsigned n, r;
    for (int unsigned i = 0; i < nb; i++) begin
      b[63:0]  = {$urandom, $urandom};
      b[71:64] = 8'($urandom);
      b[72]    = (i == nb - 1);
      beats.push_back(b);
    end
    exp_rd += nb;
    if (drop || len == 16'd0 || int'(len) > int'(MAXL)) begin
      m_drop++;
    end else begin
      n = (int'(len) + 7) / 8;
      r = int'(len) % 8;
      for (int unsigned i = 1; i <= nb; i++) begin
        b = beats[i-1];
        if (i < n) begin
          exp_q.push_back(b);
          exp_wr++;
          if (i == nb) begin
            m_tx++;
            m_lerr++;
            break;
          end
        end else begin
          b[72]    = 1'b1;
          b[71:64] = (r == 0) ? 8'hFF : 8'(8'hFF >> (8 - r));
          exp_q.push_back(b);
          exp_wr++;
          if (i == nb) m_tx++;
          else m_lerr++;
          break;
        end
      end
    end
    foreach (beats[i]) dq.push_back(beats[i]);
    if (with_desc) cq.push_back({drop, 17'($urandom), len});
  endtask

  task automatic wait_idle(input string nm, input int cq_left);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge tx_clk);
      #2;
      if (!busy && cq.size() == cq_left && dq.size() == 0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: busy=%0d cq=%0d dq=%0d exp=%0d, expected drained",
               nm, busy, cq.size(), dq.size(), exp_q.size());
    end
    chk_n({nm, "_tx_frames"}, stat_tx_frames, m_tx);
    chk_n({nm, "_drop_frames"}, stat_drop_frames, m_drop);
    chk_n({nm, "_len_err"}, stat_len_err, m_lerr);
    chk_n({nm, "_writes"}, mon_wr, exp_wr);
    chk_n({nm, "_reads"}, mon_rd, exp_rd);
  endtask

  task automatic wait_writes(input string nm, input int unsigned target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge tx_clk);
      #3;
      if (mon_wr >= target) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: writes %0d, expected %0d", nm, mon_wr, target);
    end
  endtask

  initial begin : stim
    int unsigned c0, w0, kind, nb, len;
    logic ok;
    sys_rst_n = 1'b0;
    sched_en  = 1'b1;
    #22;
    chk_n("rst_busy", 32'(busy), 32'd0);
    chk_n("rst_wren", 32'(tx_fifo_wren), 32'd0);
    chk_n("rst_drden", 32'(data_fifo_rden), 32'd0);
    chk_b("rst_wdata", tx_fifo_wdata, 73'd0);
    chk_n("rst_stat_tx", stat_tx_frames, 32'd0);
    @(posedge tx_clk);
    #3;
    sys_rst_n = 1'b1;

    // Full-length frame, and a frame with a partial last beat plus a stall.
    send_frame(16'd64, 1'b0, 8, 1'b1);
    wait_idle("len64", 0);
    send_frame(16'd61, 1'b0, 8, 1'b1);
    wait_writes("stall_pre", mon_wr + 3);
    hold_afull = 1'b1;
    @(posedge tx_clk);
    #2;
    w0 = mon_wr;
    repeat (4) @(posedge tx_clk);
    #2;
    chk_n("stall_no_writes", mon_wr, w0);
    hold_afull = 1'b0;
    wait_idle("len61_stall", 0);

    // Drop paths and the length limit boundary.
    send_frame(16'd128, 1'b1, 16, 1'b1);
    wait_idle("drop128", 0);
    send_frame(16'd0, 1'b0, 3, 1'b1);
    wait_idle("len0", 0);
    send_frame(16'(MAXL + 1), 1'b0, 2, 1'b1);
    wait_idle("len_over", 0);
    send_frame(16'(MAXL), 1'b0, MAXL / 8, 1'b1);
    wait_idle("len_max", 0);

    // Short and long source frames.
    send_frame(16'd64, 1'b0, 5, 1'b1);
    wait_idle("early_tlast", 0);
    send_frame(16'd16, 1'b0, 4, 1'b1);
    wait_idle("late_tlast", 0);

    // Scheduler enable only gates IDLE.
    sched_en = 1'b0;
    c0 = mon_crd;
    send_frame(16'd32, 1'b0, 4, 1'b1);
    repeat (20) @(posedge tx_clk);
    #2;
    chk_n("en_low_no_pop", mon_crd - c0, 32'd0);
    chk_n("en_low_not_busy", 32'(busy), 32'd0);
    sched_en = 1'b1;
    wait_idle("en_resume", 0);

    afull_pct = 50;
    c0 = mon_crd;
    send_frame(16'd80, 1'b0, 10, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge tx_clk);
      #2;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk_n("en_mid_started", 32'(ok), 32'd1);
    sched_en = 1'b0;
    cq.push_back({1'b0, 17'd0, 16'd24});
    wait_idle("en_mid_complete", 1);
    chk_n("en_mid_one_pop", mon_crd - c0, 32'd1);
    sched_en = 1'b1;
    send_frame(16'd24, 1'b0, 3, 1'b0);
    wait_idle("en_mid_next", 0);
    afull_pct = 0;

    // Reset in the middle of beat 3.
    send_frame(16'd64, 1'b0, 8, 1'b1);
    wait_writes("rst_pre1", mon_wr + 1);
    cq.push_back({1'b0, 17'd0, 16'd8});
    wait_writes("rst_pre2", mon_wr + 1);
    sys_rst_n = 1'b0;
    #1;
    chk_n("midrst_wren", 32'(tx_fifo_wren), 32'd0);
    chk_n("midrst_drden", 32'(data_fifo_rden), 32'd0);
    chk_n("midrst_crden", 32'(ctrl_fifo_rden), 32'd0);
    chk_n("midrst_busy", 32'(busy), 32'd0);
    chk_b("midrst_wdata", tx_fifo_wdata, 73'd0);
    chk_n("midrst_tx", stat_tx_frames, 32'd0);
    chk_n("midrst_drop", stat_drop_frames, 32'd0);
    chk_n("midrst_lerr", stat_len_err, 32'd0);
    cq.delete();
    dq.delete();
    exp_q.delete();
    refresh();
    mon_wr = 0; mon_rd = 0; exp_wr = 0; exp_rd = 0;
    m_tx = 0; m_drop = 0; m_lerr = 0;
    repeat (2) @(posedge tx_clk);
    #3;
    sys_rst_n = 1'b1;
    send_frame(16'd40, 1'b0, 5, 1'b1);
    wait_idle("after_rst", 0);

    // Randomized batches of frames with random back-pressure.
    for (int unsigned batch = 0; batch < 10; batch++) begin
      afull_pct = $urandom_range(60);
      for (int unsigned f = 0; f < 4; f++) begin
        kind = $urandom_range(9);
        if (kind == 0) begin
          len = $urandom_range(200, 1);
          send_frame(16'(len), 1'b1, $urandom_range(30, 1), 1'b1);
        end else if (kind == 1) begin
          send_frame(16'd0, 1'b0, $urandom_range(4, 1), 1'b1);
        end else if (kind == 2) begin
          send_frame(16'(MAXL + 1 + $urandom_range(100)), 1'b0, $urandom_range(4, 1), 1'b1);
        end else begin
          len = $urandom_range(300, 1);
          nb  = (len + 7) / 8 + $urandom_range(4);
          nb  = (nb > 2) ? nb - 2 : 1;
          send_frame(16'(len), 1'b0, nb, 1'b1);
        end
      end
      wait_idle("random", 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ofm_tx_sched.md
OFM_TX_SCHED -- requirements
Module: ofm_tx_sched

Interface
REQ-001 SHALL have parameter C_MAX_LEN, default 9600, maximum legal frame length in bytes.
REQ-002 SHALL have port tx_clk  in  1  sole clock; all logic on the rising edge.
REQ-003 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sched_en  in  1  scheduler enable, level.
REQ-005 SHALL have ports ctrl_fifo_rdata  in  34, ctrl_fifo_empty  in  1, ctrl_fifo_rden  out  1  per-frame descriptor FIFO, first-word-fall-through.
REQ-006 SHALL have ports data_fifo_rdata  in  73, data_fifo_empty  in  1, data_fifo_rden  out  1  beat FIFO {tlast[72], tkeep[71:64], tdata[63:0]}, first-word-fall-through.
REQ-007 SHALL have ports tx_fifo_wdata  out  73, tx_fifo_wren  out  1, tx_fifo_afull  in  1  MAC-side TX FIFO, same beat format.
REQ-008 SHALL have port busy  out  1  high when state is not IDLE.
REQ-009 SHALL have ports stat_tx_frames, stat_drop_frames, stat_len_err  out  32 each  statistics.

Function
REQ-010 Descriptor SHALL be decoded as: [15:0] length in bytes, [33] drop, [32:16] ignored.
REQ-011 FSM states SHALL be IDLE, LOAD, XFER, DROP.
REQ-012 IDLE->LOAD when sched_en=1 and ctrl_fifo_empty=0; ctrl_fifo_rden pulses 1 cycle in IDLE on that transition.
REQ-013 LOAD SHALL latch length; beat count = ceil(length/8), 13-bit, no overflow for length<=C_MAX_LEN.
REQ-014 LOAD->DROP when drop=1, length=0, or length>C_MAX_LEN; otherwise LOAD->XFER.
REQ-015 In XFER, data_fifo_rden = tx_fifo_wren = (data_fifo_empty=0 and tx_fifo_afull=0), combinational, same cycle, zero latency.
REQ-016 tx_fifo_wdata SHALL equal data_fifo_rdata, except on the counted last beat: bit72 forced 1, tkeep = 8'hFF if length[2:0]=0 else (1<<length[2:0])-1.
REQ-017 Counted last beat with input tlast=1: XFER->IDLE, stat_tx_frames+1.
REQ-018 Input tlast=1 before counted last beat: beat written as-is, XFER->IDLE, stat_tx_frames+1 and stat_len_err+1.
REQ-019 Counted last beat with input tlast=0: beat written with tlast forced, XFER->DROP, stat_len_err+1.
REQ-020 In DROP, data_fifo_rden = ~data_fifo_empty, tx_fifo_wren=0; on consumed beat with tlast=1 -> IDLE, stat_drop_frames+1 (only when entered from LOAD).
REQ-021 sched_en deassertion SHALL affect only IDLE; frame in progress completes.
REQ-022 tx_fifo_afull=1 SHALL stall XFER indefinitely without losing beat or count state; DROP ignores tx_fifo_afull.
REQ-023 Statistic counters SHALL saturate at 32'hFFFFFFFF.
REQ-024 ctrl_fifo_rden SHALL never assert outside IDLE; at most one descriptor outstanding.

Reset
REQ-025 sys_rst_n=0 SHALL immediately force state IDLE, beat counter 0, latched length 0, all stat counters 0, ctrl_fifo_rden=data_fifo_rden=tx_fifo_wren=0, busy=0, tx_fifo_wdata=0 when not writing.
REQ-026 Reset mid-frame SHALL abandon the frame; no resync attempted on release beyond normal IDLE operation.

Structure
REQ-027 Package ofm_pkg SHALL hold the state enum, descriptor field offsets (LEN, DROP), beat field offsets (TLAST, TKEEP, TDATA) and C_MAX_LEN default.
REQ-028 Sub-module ofm_stat_cnt (32-bit saturating incrementer, async active-low reset) SHALL be instantiated three times.

Verification
REQ-029 Descriptor len=64, 8 beats tlast on 8th -> 8 writes, last tkeep=8'hFF, stat_tx_frames=1.
REQ-030 len=61, 8 beats -> last beat tkeep=8'h1F, tlast=1; tx_fifo_afull held 1 for 5 cycles mid-frame -> no wren during stall, output byte-identical.
REQ-031 drop=1, len=128, 16 beats -> zero writes, 16 rdens, stat_drop_frames=1; len=0 and len=9601 each -> drop.
REQ-032 len=64, input tlast on beat 5 -> 5 writes, stat_len_err=1; len=16 with 4 beats tlast on 4th -> 2 writes (2nd tlast forced), 2 beats discarded, stat_len_err=1.
REQ-033 sys_rst_n low during beat 3 of 8 -> outputs 0 within same cycle, counters 0; next descriptor after release sent correctly.
REQ-034 sched_en=0 with descriptors queued -> ctrl_fifo_rden stays 0; sched_en dropped mid-frame -> frame completes, then IDLE.
